bram_tdp_be: RTL



---
 rtl/bram_tdp_be_pkg.sv | 27 ++
 rtl/bram_tdp_be_if.sv | 17 +
 rtl/bram_tdp_be_rd_pipe.sv | 51 +++++
 rtl/bram_tdp_be.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/bram_tdp_be_pkg.sv
// Shared types and helpers for the true dual-port byte-enable BRAM.
// Optional clear sweep is selected with the BRAM_CLEAR_EN macro (see bram_tdp_be.sv).
package bram_pkg;

  typedef enum logic {
    READ_FIRST  = 1'b0,
    WRITE_FIRST = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clear_state_e;

  function automatic int num_bytes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

  // Word must split into whole lanes, latency is 1 or 2, RDW mode is 0 or 1.
  function automatic bit params_ok(input int data_width, input int byte_width,
                                   input int rd_latency, input int rdw_mode);
    return (byte_width > 0) && (data_width % byte_width == 0) &&
           (rd_latency == 1 || rd_latency == 2) &&
           (rdw_mode == 0 || rdw_mode == 1);
  endfunction

endpackage

// File: rtl/bram_tdp_be_if.sv
// One RAM port: request, byte-lane write data and the returned read data/valid.
interface bram_tdp_be_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_BYTES  = DATA_WIDTH / 8
);
  logic                  en;
  logic                  wr;
  logic [NUM_BYTES-1:0]  be;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;

  modport master (output en, wr, be, addr, data_in, input data_out, valid);
  modport slave  (input en, wr, be, addr, data_in, output data_out, valid);
endinterface

// File: rtl/bram_tdp_be_rd_pipe.sv
// Per-port read output pipeline: LATENCY register stages for data and valid.
// Data registers only load on a valid beat so data_out holds between results.
module bram_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [DATA_WIDTH-1:0] rd_word,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid
);

  logic                  v1_q;
  logic [DATA_WIDTH-1:0] d1_q;

  // First stage: capture the addressed word for every accepted request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= req;
      if (req) d1_q <= rd_word;
    end
  end

  if (LATENCY == 2) begin : g_lat2
    logic                  v2_q;
    logic [DATA_WIDTH-1:0] d2_q;

    // Extra output register stage, valid follows the same path.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) d2_q <= d1_q;
      end
    end

    assign data_out = d2_q;
    assign valid    = v2_q;
  end else begin : g_lat1
    assign data_out = d1_q;
    assign valid    = v1_q;
  end

endmodule

// File: rtl/bram_tdp_be.sv
// Single-clock true dual-port RAM with byte enables, read pipeline, RDW select,
// same-address write arbitration (A wins, B dropped) and an optional zero sweep.
// Macro BRAM_CLEAR_EN: when defined, a clear FSM zeroes the whole memory after
// reset release and on clear_req; when undefined, busy is tied low.
//
// state | meaning
// CLEAR | sweeping zeros, one word per cycle; port requests ignored, busy=1
// READY | normal operation; clear_req restarts the sweep at address 0
module bram_tdp_be
  import bram_pkg::*;
#(
  parameter int RAM_DATA_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int RAM_BYTE_WIDTH = 8,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  output logic          busy,
  output logic          collision,
  bram_tdp_be_if.slave  a_port,
  bram_tdp_be_if.slave  b_port
);

  localparam int NUM_BYTES = num_bytes(RAM_DATA_WIDTH, RAM_BYTE_WIDTH);
  localparam int DEPTH     = 2 ** RAM_ADDR_WIDTH;
  localparam bit WR_FIRST  = (RDW_MODE == int'(WRITE_FIRST));

  if (!params_ok(RAM_DATA_WIDTH, RAM_BYTE_WIDTH, RD_LATENCY, RDW_MODE)) begin : g_bad_params
    $error("bram_tdp_be: illegal width/latency/RDW parameter combination");
  end

  typedef logic [RAM_DATA_WIDTH-1:0] word_t;

  word_t mem [DEPTH];

  logic                      clr_we;
  logic [RAM_ADDR_WIDTH-1:0] clr_addr;

  logic  a_acc, b_acc;
  logic  a_wr_eff, b_wr_eff;
  logic  same_addr_wr, b_wr_kept;
  word_t a_old, b_old;
  word_t a_merged, b_merged;
  word_t a_rd_word, b_rd_word;

`ifdef BRAM_CLEAR_EN
  clear_state_e              state_q;
  logic [RAM_ADDR_WIDTH-1:0] clr_addr_q;

  // Clear FSM: reset lands in CLEAR so the sweep starts right after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_addr_q <= clr_addr_q + RAM_ADDR_WIDTH'(1);
          if (clr_addr_q == '1) state_q <= READY;
        end
        READY: begin
          if (clear_req) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
          end
        end
        default: state_q <= READY;
      endcase
    end
  end

  assign busy     = (state_q == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = clr_addr_q;
`else
  logic unused_clear_req;

  assign unused_clear_req = clear_req;
  assign busy             = 1'b0;
  assign clr_we           = 1'b0;
  assign clr_addr         = '0;
`endif

  // A write with no lanes enabled is treated as a read everywhere below.
  assign a_acc    = a_port.en & ~busy;
  assign b_acc    = b_port.en & ~busy;
  assign a_wr_eff = a_acc & a_port.wr & (|a_port.be);
  assign b_wr_eff = b_acc & b_port.wr & (|b_port.be);

  assign same_addr_wr = a_wr_eff & b_wr_eff & (a_port.addr == b_port.addr);
  assign b_wr_kept    = b_wr_eff & ~same_addr_wr;

  assign a_old = mem[a_port.addr];
  assign b_old = mem[b_port.addr];

  // Byte-lane merge of each port's write data over the stored word.
  always_comb begin
    a_merged = a_old;
    b_merged = b_old;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (a_port.be[i])
        a_merged[i*RAM_BYTE_WIDTH +: RAM_BYTE_WIDTH] = a_port.data_in[i*RAM_BYTE_WIDTH +: RAM_BYTE_WIDTH];
      if (b_port.be[i])
        b_merged[i*RAM_BYTE_WIDTH +: RAM_BYTE_WIDTH] = b_port.data_in[i*RAM_BYTE_WIDTH +: RAM_BYTE_WIDTH];
    end
  end

  // Write-first only changes a port's view of its own write; the other port
  // always reads the stored (pre-write) word. A colliding B still sees its own merge.
  assign a_rd_word = (WR_FIRST && a_wr_eff) ? a_merged : a_old;
  assign b_rd_word = (WR_FIRST && b_wr_eff) ? b_merged : b_old;

  // Memory array update: sweep has priority, then B, then A so A wins any tie.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (b_wr_kept) mem[b_port.addr] <= b_merged;
      if (a_wr_eff)  mem[a_port.addr] <= a_merged;
    end
  end

  // Collision flag, one cycle after the colliding writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) collision <= 1'b0;
    else      collision <= same_addr_wr;
  end

  bram_rd_pipe #(
    .DATA_WIDTH (RAM_DATA_WIDTH),
    .LATENCY    (RD_LATENCY)
  ) u_a_pipe (
    .clk      (clk),
    .rst      (rst),
    .req      (a_acc),
    .rd_word  (a_rd_word),
    .data_out (a_port.data_out),
    .valid    (a_port.valid)
  );

  bram_rd_pipe #(
    .DATA_WIDTH (RAM_DATA_WIDTH),
    .LATENCY    (RD_LATENCY)
  ) u_b_pipe (
    .clk      (clk),
    .rst      (rst),
    .req      (b_acc),
    .rd_word  (b_rd_word),
    .data_out (b_port.data_out),
    .valid    (b_port.valid)
  );

endmodule
